// File: rtl/dsi_sched_pkg.sv
// Shared types for the DSI HS packet scheduler.
// State encoding and source indices used by scheduler and arbiter.
package dsi_sched_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_CLK_UP = 3'd1,
        ST_ON     = 3'd2,
        ST_START  = 3'd3,
        ST_XFER   = 3'd4,
        ST_GAP    = 3'd5,
        ST_CLK_DN = 3'd6
    } sched_state_t;

    localparam logic SRC_SPI = 1'b0;
    localparam logic SRC_AUX = 1'b1;

endpackage

// File: rtl/dsi_rr_arb2.sv
// Two-way round-robin arbiter for the DSI HS scheduler.
// Holds the favoured source; winner is combinational from the requests.
module dsi_rr_arb2
    import dsi_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_upd,
    input  logic i_served,
    output logic o_win
);

    logic r_ptr;

    // Favour the source that was not served by the packet just completed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= SRC_SPI;
        end else if (i_upd) begin
            r_ptr <= ~i_served;
        end
    end

    // Contention goes to the favoured source, otherwise the lone requester
    always_comb begin
        o_win = SRC_SPI;
        if (i_req0 && i_req1) begin
            o_win = r_ptr;
        end else if (i_req1) begin
            o_win = SRC_AUX;
        end
    end

endmodule

// File: rtl/dsi_hs_sched.sv
// DSI HS scheduler: shares the HS packet port between two sources
// and sequences the HS clock lane around packet traffic.
module dsi_hs_sched
    import dsi_sched_pkg::*;
#(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    input  logic [7:0]    s0_data,
    input  logic          s0_last,
    output logic          s0_ack,
    input  logic          s1_valid,
    input  logic [7:0]    s1_data,
    input  logic          s1_last,
    output logic          s1_ack,
    output logic          hs_start,
    output logic [7:0]    hs_data,
    output logic          hs_last,
    input  logic          hs_ack,
    input  logic          hs_rdy,
    output logic          hs_clk_req,
    input  logic          hs_clk_rdy,
    input  logic          cfg_clk_force,
    input  logic [TW-1:0] cfg_idle_timeout,
    output logic          busy,
    output logic          grant,
    output logic [15:0]   stat_pkt_cnt
);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    logic          r_grant;
    logic [TW-1:0] r_idle_cnt;
    logic [TW-1:0] w_idle_nxt;
    logic [15:0]   r_pkt_cnt;
    logic [15:0]   w_pkt_cnt_nxt;
    logic          w_any_valid;
    logic          w_pend;
    logic          w_xfer;
    logic          w_grant_ld;
    logic          w_pkt_done;
    logic          w_win;

    assign w_any_valid = s0_valid | s1_valid;
    assign w_pend      = w_any_valid | cfg_clk_force;

    assign hs_data = r_grant ? s1_data : s0_data;
    assign hs_last = r_grant ? s1_last : s0_last;
    assign s0_ack  = w_xfer & (r_grant == SRC_SPI) & hs_ack;
    assign s1_ack  = w_xfer & (r_grant == SRC_AUX) & hs_ack;

    assign w_pkt_done   = w_xfer & hs_ack & hs_last;
    assign grant        = r_grant;
    assign stat_pkt_cnt = r_pkt_cnt;

    dsi_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req0   (s0_valid),
        .i_req1   (s1_valid),
        .i_upd    (w_pkt_done),
        .i_served (r_grant),
        .o_win    (w_win)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state output decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant_ld  = 1'b0;
        w_xfer      = 1'b0;
        hs_start    = 1'b0;
        busy        = 1'b0;
        hs_clk_req  = 1'b1;
        unique case (r_state)
            ST_OFF: begin
                hs_clk_req = 1'b0;
                if (w_pend) begin
                    w_state_nxt = ST_CLK_UP;
                end
            end
            ST_CLK_UP: begin
                if (hs_clk_rdy) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (w_any_valid && hs_rdy) begin
                    w_grant_ld  = 1'b1;
                    w_state_nxt = ST_START;
                end else if (!cfg_clk_force &&
                             (r_idle_cnt >= cfg_idle_timeout)) begin
                    w_state_nxt = ST_CLK_DN;
                end
            end
            ST_START: begin
                hs_start = 1'b1;
                busy     = 1'b1;
                w_xfer   = 1'b1;
                if (hs_ack) begin
                    w_state_nxt = hs_last ? ST_GAP : ST_XFER;
                end
            end
            ST_XFER: begin
                busy   = 1'b1;
                w_xfer = 1'b1;
                if (hs_ack && hs_last) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (hs_rdy) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_CLK_DN: begin
                hs_clk_req = 1'b0;
                if (!hs_clk_rdy) begin
                    w_state_nxt = ST_OFF;
                end
            end
            default: begin
                hs_clk_req  = 1'b0;
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // Grant is locked at packet start and held until the next start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= SRC_SPI;
        end else if (w_grant_ld) begin
            r_grant <= w_win;
        end
    end

    // Idle counter runs only while ON; saturates so a held force cannot wrap it
    always_comb begin
        w_idle_nxt = '0;
        if (r_state == ST_ON) begin
            if (r_idle_cnt != '1) begin
                w_idle_nxt = r_idle_cnt + TW'(1);
            end else begin
                w_idle_nxt = r_idle_cnt;
            end
        end
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= w_idle_nxt;
        end
    end

    // Completed-packet count, free-running wrap
    always_comb begin
        w_pkt_cnt_nxt = r_pkt_cnt;
        if (w_pkt_done) begin
            w_pkt_cnt_nxt = r_pkt_cnt + 16'd1;
        end
    end

    // Packet counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= 16'd0;
        end else begin
            r_pkt_cnt <= w_pkt_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dsi_hs_sched.sv
// Directed self-checking bench for dsi_hs_sched.
// Source FIFOs are modelled as queues popped on their ack.
module tb_dsi_hs_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid;
    logic [7:0]  s0_data;
    logic        s0_last;
    logic        s0_ack;
    logic        s1_valid;
    logic [7:0]  s1_data;
    logic        s1_last;
    logic        s1_ack;
    logic        hs_start;
    logic [7:0]  hs_data;
    logic        hs_last;
    logic        hs_ack;
    logic        hs_rdy;
    logic        hs_clk_req;
    logic        hs_clk_rdy;
    logic        cfg_clk_force;
    logic [15:0] cfg_idle_timeout;
    logic        busy;
    logic        grant;
    logic [15:0] stat_pkt_cnt;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int ntotal = 0;
    int nbad = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;

    always #5 clk = ~clk;

    dsi_hs_sched #(.TW(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .s0_valid         (s0_valid),
        .s0_data          (s0_data),
        .s0_last          (s0_last),
        .s0_ack           (s0_ack),
        .s1_valid         (s1_valid),
        .s1_data          (s1_data),
        .s1_last          (s1_last),
        .s1_ack           (s1_ack),
        .hs_start         (hs_start),
        .hs_data          (hs_data),
        .hs_last          (hs_last),
        .hs_ack           (hs_ack),
        .hs_rdy           (hs_rdy),
        .hs_clk_req       (hs_clk_req),
        .hs_clk_rdy       (hs_clk_rdy),
        .cfg_clk_force    (cfg_clk_force),
        .cfg_idle_timeout (cfg_idle_timeout),
        .busy             (busy),
        .grant            (grant),
        .stat_pkt_cnt     (stat_pkt_cnt)
    );

    task automatic drive_srcs();
        s0_valid = (q0.size() > 0);
        s0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        s0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
        s1_valid = (q1.size() > 0);
        s1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        s1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
    endtask

    task automatic tick();
        logic a0;
        logic a1;
        drive_srcs();
        #1;
        a0 = s0_ack;
        a1 = s1_ack;
        if (a0) ack0_cnt++;
        if (a1) ack1_cnt++;
        @(posedge clk);
        #1;
        if (a0 && q0.size() > 0) void'(q0.pop_front());
        if (a1 && q1.size() > 0) void'(q1.pop_front());
        drive_srcs();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        hs_ack = 1'b1;
        hs_rdy = 1'b1;
        hs_clk_rdy = 1'b0;
        cfg_clk_force = 1'b0;
        cfg_idle_timeout = 16'd8;
        tick();
        tick();
        rst = 1'b0;
        ack0_cnt = 0;
        ack1_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        ntotal++;
        if (hs_clk_req !== 1'b0) begin
            nbad++; $display("FAIL rst_clk_req got %b exp 0", hs_clk_req);
        end
        ntotal++;
        if (hs_start !== 1'b0) begin
            nbad++; $display("FAIL rst_start got %b exp 0", hs_start);
        end
        ntotal++;
        if ({busy, grant, s0_ack, s1_ack} !== 4'b0000) begin
            nbad++;
            $display("FAIL rst_flags got %b exp 0000",
                     {busy, grant, s0_ack, s1_ack});
        end
        ntotal++;
        if (stat_pkt_cnt !== 16'h0000) begin
            nbad++; $display("FAIL rst_cnt got %h exp 0000", stat_pkt_cnt);
        end
    endtask

    task automatic test_cold_start();
        q0.push_back(9'h0A1);
        q0.push_back(9'h0A2);
        q0.push_back(9'h1A3);
        drive_srcs();
        #1;
        ntotal++;
        if (hs_clk_req !== 1'b0) begin
            nbad++; $display("FAIL cold_off_req got %b exp 0", hs_clk_req);
        end
        tick();
        ntotal++;
        if (hs_clk_req !== 1'b1) begin
            nbad++; $display("FAIL cold_clkup_req got %b exp 1", hs_clk_req);
        end
        hs_clk_rdy = 1'b1;
        tick();
        ntotal++;
        if (hs_start !== 1'b0) begin
            nbad++; $display("FAIL cold_early_start got %b exp 0", hs_start);
        end
        tick();
        ntotal++;
        if ({hs_start, busy, grant, s0_ack} !== 4'b1101) begin
            nbad++;
            $display("FAIL cold_start_flags got %b exp 1101",
                     {hs_start, busy, grant, s0_ack});
        end
        ntotal++;
        if ({hs_last, hs_data} !== 9'h0A1) begin
            nbad++; $display("FAIL cold_byte1 got %h exp 0a1", {hs_last, hs_data});
        end
        tick();
        ntotal++;
        if ({hs_start, hs_last, hs_data} !== 10'h0A2) begin
            nbad++;
            $display("FAIL cold_byte2 got %h exp 0a2", {hs_start, hs_last, hs_data});
        end
        tick();
        ntotal++;
        if ({hs_last, hs_data} !== 9'h1A3) begin
            nbad++; $display("FAIL cold_byte3 got %h exp 1a3", {hs_last, hs_data});
        end
        tick();
        ntotal++;
        if (stat_pkt_cnt !== 16'd1) begin
            nbad++; $display("FAIL cold_cnt got %0d exp 1", stat_pkt_cnt);
        end
        ntotal++;
        if (ack0_cnt !== 3) begin
            nbad++; $display("FAIL cold_acks got %0d exp 3", ack0_cnt);
        end
        ntotal++;
        if ({busy, s0_ack} !== 2'b00) begin
            nbad++; $display("FAIL cold_gap got %b exp 00", {busy, s0_ack});
        end
    endtask

    task automatic test_idle_drop();
        tick();
        repeat (8) tick();
        ntotal++;
        if (hs_clk_req !== 1'b1) begin
            nbad++; $display("FAIL idle_early_drop got %b exp 1", hs_clk_req);
        end
        tick();
        ntotal++;
        if (hs_clk_req !== 1'b0) begin
            nbad++; $display("FAIL idle_drop got %b exp 0", hs_clk_req);
        end
    endtask

    task automatic test_clkdn_single();
        q1.push_back(9'h15A);
        repeat (3) tick();
        ntotal++;
        if (hs_clk_req !== 1'b0) begin
            nbad++; $display("FAIL clkdn_hold got %b exp 0", hs_clk_req);
        end
        hs_clk_rdy = 1'b0;
        tick();
        ntotal++;
        if (hs_clk_req !== 1'b0) begin
            nbad++; $display("FAIL clkdn_off got %b exp 0", hs_clk_req);
        end
        tick();
        ntotal++;
        if (hs_clk_req !== 1'b1) begin
            nbad++; $display("FAIL clkdn_reup got %b exp 1", hs_clk_req);
        end
        hs_clk_rdy = 1'b1;
        tick();
        tick();
        ntotal++;
        if ({hs_start, grant, s1_ack, s0_ack} !== 4'b1110) begin
            nbad++;
            $display("FAIL single_flags got %b exp 1110",
                     {hs_start, grant, s1_ack, s0_ack});
        end
        ntotal++;
        if ({hs_last, hs_data} !== 9'h15A) begin
            nbad++; $display("FAIL single_byte got %h exp 15a", {hs_last, hs_data});
        end
        tick();
        ntotal++;
        if ({hs_start, busy} !== 2'b00) begin
            nbad++; $display("FAIL single_gap got %b exp 00", {hs_start, busy});
        end
        ntotal++;
        if (stat_pkt_cnt !== 16'd2) begin
            nbad++; $display("FAIL single_cnt got %0d exp 2", stat_pkt_cnt);
        end
    endtask

    task automatic test_contention();
        logic [4:0] exp_g;
        logic [4:0] got_g;
        logic [7:0] exp_b;
        logic prev_start;
        bit fill1;
        int nstart;
        exp_g = 5'b01010;
        got_g = '0;
        do_reset();
        hs_clk_rdy = 1'b1;
        fill1 = 1'b0;
        nstart = 0;
        prev_start = 1'b0;
        for (int c = 0; c < 200 && nstart < 5; c++) begin
            if (q0.size() == 0) begin
                q0.push_back(9'h010);
                q0.push_back(9'h111);
            end
            if (fill1 && q1.size() == 0) begin
                q1.push_back(9'h020);
                q1.push_back(9'h121);
            end
            drive_srcs();
            #1;
            if (hs_start && !prev_start) begin
                got_g[nstart] = grant;
                exp_b = exp_g[nstart] ? 8'h20 : 8'h10;
                ntotal++;
                if (hs_data !== exp_b) begin
                    nbad++;
                    $display("FAIL cont_byte%0d got %h exp %h", nstart, hs_data, exp_b);
                end
                nstart++;
                fill1 = 1'b1;
            end
            ntotal++;
            if ((s1_ack && !grant) || (s0_ack && grant)) begin
                nbad++;
                $display("FAIL cont_ack_gate got s0=%b s1=%b g=%b exp no ack off-grant",
                         s0_ack, s1_ack, grant);
            end
            prev_start = hs_start;
            tick();
        end
        ntotal++;
        if (nstart != 5) begin
            nbad++; $display("FAIL cont_starts got %0d exp 5", nstart);
        end
        ntotal++;
        if (got_g !== exp_g) begin
            nbad++; $display("FAIL cont_grant_seq got %b exp %b", got_g, exp_g);
        end
    endtask

    task automatic test_force();
        int drops;
        do_reset();
        hs_clk_rdy = 1'b1;
        cfg_clk_force = 1'b1;
        tick();
        ntotal++;
        if (hs_clk_req !== 1'b1) begin
            nbad++; $display("FAIL force_up got %b exp 1", hs_clk_req);
        end
        tick();
        drops = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (hs_clk_req !== 1'b1) drops++;
        end
        ntotal++;
        if (drops != 0) begin
            nbad++; $display("FAIL force_hold got %0d drops exp 0", drops);
        end
        cfg_idle_timeout = 16'd0;
        cfg_clk_force = 1'b0;
        #1;
        ntotal++;
        if (hs_clk_req !== 1'b1) begin
            nbad++; $display("FAIL force_release_now got %b exp 1", hs_clk_req);
        end
        tick();
        ntotal++;
        if (hs_clk_req !== 1'b0) begin
            nbad++; $display("FAIL force_release_drop got %b exp 0", hs_clk_req);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int c;
        do_reset();
        hs_clk_rdy = 1'b1;
        q1.push_back(9'h031);
        q1.push_back(9'h132);
        c = 0;
        while (stat_pkt_cnt != 16'd1 && c < 30) begin
            tick();
            c++;
        end
        q1.push_back(9'h041);
        q1.push_back(9'h042);
        q1.push_back(9'h043);
        q1.push_back(9'h144);
        c = 0;
        while (!(busy && !hs_start) && c < 30) begin
            tick();
            c++;
        end
        ntotal++;
        if ({busy, grant, stat_pkt_cnt} !== {2'b11, 16'd1}) begin
            nbad++;
            $display("FAIL midx_pre got busy=%b g=%b cnt=%0d exp 1 1 1",
                     busy, grant, stat_pkt_cnt);
        end
        rst = 1'b1;
        tick();
        ntotal++;
        if ({hs_clk_req, hs_start, busy, grant, s0_ack, s1_ack} !== 6'b0) begin
            nbad++;
            $display("FAIL midx_flags got %b exp 000000",
                     {hs_clk_req, hs_start, busy, grant, s0_ack, s1_ack});
        end
        ntotal++;
        if ({hs_last, hs_data, stat_pkt_cnt} !== 25'h0) begin
            nbad++;
            $display("FAIL midx_data got last=%b data=%h cnt=%h exp 0",
                     hs_last, hs_data, stat_pkt_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        int c;
        do_reset();
        force dut.r_pkt_cnt = 16'hFFFF;
        tick();
        release dut.r_pkt_cnt;
        #1;
        ntotal++;
        if (stat_pkt_cnt !== 16'hFFFF) begin
            nbad++; $display("FAIL wrap_preload got %h exp ffff", stat_pkt_cnt);
        end
        hs_clk_rdy = 1'b1;
        q0.push_back(9'h0C1);
        q0.push_back(9'h1C2);
        c = 0;
        while (stat_pkt_cnt == 16'hFFFF && c < 30) begin
            tick();
            c++;
        end
        ntotal++;
        if (stat_pkt_cnt !== 16'h0000) begin
            nbad++; $display("FAIL wrap_cnt got %h exp 0000", stat_pkt_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        hs_ack = 1'b1;
        hs_rdy = 1'b1;
        hs_clk_rdy = 1'b0;
        cfg_clk_force = 1'b0;
        cfg_idle_timeout = 16'd8;
        drive_srcs();
        test_reset();
        test_cold_start();
        test_idle_drop();
        test_clkdn_single();
        test_contention();
        test_force();
        test_reset_mid_xfer();
        test_wrap();
        $display("test done: total=%0d bad=%0d", ntotal, nbad);
        $finish;
    end

endmodule
